// File: rtl/timer_keypad_loader_pkg.sv
// Shared constants and state encoding for the countdown-timer keypad loader.
package timer_keypad_loader_pkg;

  localparam int unsigned DigitsMaxDefault = 3;
  localparam int unsigned BcdWidth         = 4;
  localparam int unsigned NumKeys          = 10;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StEntry = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/timer_keypad_loader_keypad_encoder.sv
// Registers the keypad, detects a fresh single-key press and encodes it to BCD.
module keypad_encoder
  import timer_keypad_loader_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [NumKeys-1:0]  keypad,
  output logic                press_valid,
  output logic [BcdWidth-1:0] digit
);

  logic [NumKeys-1:0] kp_q;
  logic [NumKeys-1:0] kp_prev;

  // Capture the key level and keep the previous sample for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kp_q    <= '0;
      kp_prev <= '0;
    end else begin
      kp_q    <= keypad;
      kp_prev <= kp_q;
    end
  end

  // A press counts only when one key appears from an all-released keypad, so a held
  // key gives one press and multi-key chords (and their partial releases) give none.
  always_comb begin
    press_valid = $onehot(kp_q) && (kp_prev == '0);
    digit       = '0;
    for (int i = 0; i < NumKeys; i++) begin
      if (kp_q[i]) digit = BcdWidth'(i);
    end
  end

endmodule

// File: rtl/timer_keypad_loader.sv
// Keypad/button front end for the minutes:seconds countdown timer: loads BCD digits
// with single-cycle loadn pulses and sequences run/pause/done.
module timer_keypad_loader
  import timer_keypad_loader_pkg::*;
#(
  parameter int unsigned DIGITS_MAX = DigitsMaxDefault
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NumKeys-1:0]  keypad,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                door_closed,
  input  logic                timer_zero,
  output logic [BcdWidth-1:0] data,
  output logic                loadn,
  output logic                clrn_out,
  output logic                en_out,
  output logic                mag_on,
  output logic                done
);

  localparam int unsigned CntW = $clog2(DIGITS_MAX + 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     digit_count_q, digit_count_d;
  logic                load;
  logic                press_valid;
  logic [BcdWidth-1:0] digit;
  logic                clear_q;

  logic [BcdWidth-1:0] data_q, data_d;
  logic                loadn_q, loadn_d;
  logic                clrn_q, clrn_d;
  logic                mag_on_q, mag_on_d;
  logic                done_q, done_d;

  keypad_encoder u_keypad_encoder (
    .clock       (clock),
    .reset       (reset),
    .keypad      (keypad),
    .press_valid (press_valid),
    .digit       (digit)
  );

  // State, digit counter and clear-button history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      digit_count_q <= '0;
      clear_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_count_q <= digit_count_d;
      clear_q       <= clear;
    end
  end

  // Next state and digit loading; event priority clear > door > stop > zero > start > key.
  always_comb begin
    state_d       = state_q;
    digit_count_d = digit_count_q;
    load          = 1'b0;
    if (clear) begin
      state_d       = StIdle;
      digit_count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (press_valid) begin
            load          = 1'b1;
            digit_count_d = CntW'(1);
            state_d       = StEntry;
          end
        end
        StEntry: begin
          if (start && door_closed && !timer_zero && !stop) begin
            state_d = StRun;
          end else if (press_valid && (digit_count_q < CntW'(DIGITS_MAX))) begin
            load          = 1'b1;
            digit_count_d = digit_count_q + CntW'(1);
          end
        end
        StRun: begin
          if (!door_closed || stop) state_d = StPause;
          else if (timer_zero)      state_d = StDone;
        end
        StPause: begin
          if (start && door_closed && !stop) state_d = StRun;
        end
        StDone: begin
          if (!door_closed) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output next values; en_out is combinational so the timer stops in the same cycle.
  always_comb begin
    data_d   = load ? digit : data_q;
    loadn_d  = ~load;
    // One-cycle clear pulse on the button's rising edge; never overlaps a load.
    clrn_d   = ~(clear && !clear_q);
    mag_on_d = (state_d == StRun);
    done_d   = (state_d == StDone);
    en_out   = (state_q == StRun) && door_closed && !timer_zero;
  end

  // Registered outputs; clrn_out resets low so the timer is cleared at power-up.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      loadn_q  <= 1'b1;
      clrn_q   <= 1'b0;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      data_q   <= data_d;
      loadn_q  <= loadn_d;
      clrn_q   <= clrn_d;
      mag_on_q <= mag_on_d;
      done_q   <= done_d;
    end
  end

  assign data     = data_q;
  assign loadn    = loadn_q;
  assign clrn_out = clrn_q;
  assign mag_on   = mag_on_q;
  assign done     = done_q;

endmodule

// File: tb/tb_timer_keypad_loader.sv
// Directed bench for timer_keypad_loader: key entry, run/pause/done and event collisions.
module tb_timer_keypad_loader;

  logic       clock;
  logic       reset;
  logic [9:0] keypad;
  logic       start;
  logic       stop;
  logic       clear;
  logic       door_closed;
  logic       timer_zero;
  logic [3:0] data;
  logic       loadn;
  logic       clrn_out;
  logic       en_out;
  logic       mag_on;
  logic       done;

  int errors = 0;
  int checks = 0;

  timer_keypad_loader #(
    .DIGITS_MAX (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .keypad      (keypad),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .door_closed (door_closed),
    .timer_zero  (timer_zero),
    .data        (data),
    .loadn       (loadn),
    .clrn_out    (clrn_out),
    .en_out      (en_out),
    .mag_on      (mag_on),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Apply a key pattern for 'hold' edges and watch loadn for a pulse at N+1.
  task automatic press_key(input logic [9:0] pat, input int hold, input logic exp_pulse,
                           input logic [3:0] exp_data, input string name);
    int         lows;
    int         low_at;
    logic [3:0] dat_at;
    lows   = 0;
    low_at = -1;
    dat_at = '0;
    keypad = pat;
    for (int i = 1; i <= hold + 3; i++) begin
      tick();
      if (i == hold) keypad = '0;
      if (loadn === 1'b0) begin
        lows++;
        low_at = i;
        dat_at = data;
      end
    end
    checks++;
    if (lows !== (exp_pulse ? 1 : 0)) begin
      errors++;
      $display("FAIL %s pulse_count: got %0d expected %0d", name, lows, exp_pulse ? 1 : 0);
    end
    if (exp_pulse) begin
      checks++;
      if (low_at !== 2) begin
        errors++;
        $display("FAIL %s pulse_cycle: got %0d expected 2", name, low_at);
      end
      checks++;
      if (dat_at !== exp_data) begin
        errors++;
        $display("FAIL %s pulse_data: got %0d expected %0d", name, dat_at, exp_data);
      end
    end
    checks++;
    if (data !== exp_data) begin
      errors++;
      $display("FAIL %s held_data: got %0d expected %0d", name, data, exp_data);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({data, loadn, clrn_out, en_out, mag_on, done} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got data=%0d loadn=%b clrn=%b en=%b mag=%b done=%b expected 0 1 0 0 0 0",
               data, loadn, clrn_out, en_out, mag_on, done);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (clrn_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_clrn: got %b expected 0", clrn_out);
    end
    tick();
    checks++;
    if (clrn_out !== 1'b1 || loadn !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_clrn: got clrn=%b loadn=%b expected 1 1", clrn_out, loadn);
    end
  endtask

  task automatic test_key_entry();
    press_key(10'b0000000010, 3, 1'b1, 4'd1, "key1");
    press_key(10'b0000000100, 2, 1'b1, 4'd2, "key2");
    press_key(10'b0000001000, 1, 1'b1, 4'd3, "key3");
    press_key(10'b0000010000, 2, 1'b0, 4'd3, "key4_saturated");
  endtask

  task automatic test_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (clrn_out !== 1'b0 || loadn !== 1'b1) begin
      errors++;
      $display("FAIL clear_pulse: got clrn=%b loadn=%b expected 0 1", clrn_out, loadn);
    end
    tick();
    checks++;
    if (clrn_out !== 1'b1) begin
      errors++;
      $display("FAIL clear_release: got clrn=%b expected 1", clrn_out);
    end
  endtask

  task automatic test_multi_and_hold();
    press_key(10'b0000100100, 5, 1'b0, 4'd3, "multi_key");
    press_key(10'b0010000000, 20, 1'b1, 4'd7, "hold_key7");
  endtask

  task automatic test_run_pause();
    start = 1'b1;
    #1;
    checks++;
    if (en_out !== 1'b0) begin
      errors++;
      $display("FAIL entry_en: got %b expected 0", en_out);
    end
    tick();
    start = 1'b0;
    #1;
    checks++;
    if (en_out !== 1'b1 || mag_on !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL run_entered: got en=%b mag=%b done=%b expected 1 1 0", en_out, mag_on, done);
    end
    door_closed = 1'b0;
    #1;
    checks++;
    if (en_out !== 1'b0 || mag_on !== 1'b1) begin
      errors++;
      $display("FAIL door_open_same_cycle: got en=%b mag=%b expected 0 1", en_out, mag_on);
    end
    tick();
    checks++;
    if (mag_on !== 1'b0) begin
      errors++;
      $display("FAIL door_open_pause: got mag=%b expected 0", mag_on);
    end
    door_closed = 1'b1;
    #1;
    checks++;
    if (en_out !== 1'b0) begin
      errors++;
      $display("FAIL pause_en: got %b expected 0", en_out);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (en_out !== 1'b1 || mag_on !== 1'b1) begin
      errors++;
      $display("FAIL resume_run: got en=%b mag=%b expected 1 1", en_out, mag_on);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (mag_on !== 1'b0 || en_out !== 1'b0) begin
      errors++;
      $display("FAIL stop_pause: got mag=%b en=%b expected 0 0", mag_on, en_out);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (mag_on !== 1'b1) begin
      errors++;
      $display("FAIL restart_after_stop: got mag=%b expected 1", mag_on);
    end
  endtask

  task automatic test_done();
    timer_zero = 1'b1;
    #1;
    checks++;
    if (en_out !== 1'b0) begin
      errors++;
      $display("FAIL zero_en_same_cycle: got %b expected 0", en_out);
    end
    tick();
    checks++;
    if (mag_on !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_entered: got mag=%b done=%b expected 0 1", mag_on, done);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (clrn_out !== 1'b0 || done !== 1'b0 || mag_on !== 1'b0) begin
      errors++;
      $display("FAIL done_clear: got clrn=%b done=%b mag=%b expected 0 0 0", clrn_out, done, mag_on);
    end
    tick();
    timer_zero = 1'b0;
    checks++;
    if (clrn_out !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL done_clear_after: got clrn=%b done=%b expected 1 0", clrn_out, done);
    end
  endtask

  task automatic test_simultaneous();
    press_key(10'b0000100000, 2, 1'b1, 4'd5, "key5_entry");
    keypad = 10'b0100000000;
    tick();
    clear  = 1'b1;
    start  = 1'b1;
    tick();
    checks++;
    if (clrn_out !== 1'b0 || loadn !== 1'b1 || mag_on !== 1'b0 || data !== 4'd5) begin
      errors++;
      $display("FAIL clear_start_key: got clrn=%b loadn=%b mag=%b data=%0d expected 0 1 0 5",
               clrn_out, loadn, mag_on, data);
    end
    clear  = 1'b0;
    keypad = '0;
    tick();
    checks++;
    if (clrn_out !== 1'b1 || loadn !== 1'b1 || mag_on !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_start: got clrn=%b loadn=%b mag=%b expected 1 1 0",
               clrn_out, loadn, mag_on);
    end
    start = 1'b0;
    tick();
    press_key(10'b0000000001, 1, 1'b1, 4'd0, "key0_entry");
    timer_zero = 1'b1;
    start      = 1'b1;
    tick();
    checks++;
    if (mag_on !== 1'b0 || en_out !== 1'b0) begin
      errors++;
      $display("FAIL start_at_zero: got mag=%b en=%b expected 0 0", mag_on, en_out);
    end
    timer_zero = 1'b0;
    tick();
    start = 1'b0;
    checks++;
    if (mag_on !== 1'b1) begin
      errors++;
      $display("FAIL still_in_entry: got mag=%b expected 1", mag_on);
    end
  endtask

  task automatic test_reset_mid_run();
    reset = 1'b1;
    #1;
    checks++;
    if ({data, loadn, clrn_out, en_out, mag_on, done} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_run_reset: got data=%0d loadn=%b clrn=%b en=%b mag=%b done=%b expected 0 1 0 0 0 0",
               data, loadn, clrn_out, en_out, mag_on, done);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (clrn_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_release_clrn: got %b expected 0", clrn_out);
    end
    tick();
    checks++;
    if (clrn_out !== 1'b1 || mag_on !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_first_edge: got clrn=%b mag=%b expected 1 0", clrn_out, mag_on);
    end
  endtask

  initial begin
    reset       = 1'b1;
    keypad      = '0;
    start       = 1'b0;
    stop        = 1'b0;
    clear       = 1'b0;
    door_closed = 1'b1;
    timer_zero  = 1'b0;
    test_reset();
    test_key_entry();
    test_clear();
    test_multi_and_hold();
    test_run_pause();
    test_done();
    test_simultaneous();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
